// File: rtl/aux_keypad_scanner_pkg.sv
// aux_keypad_scanner_pkg: shared constants, FSM encodings and helpers for the
// keypad scanner. Also provides the scan-count helper macros that the clock
// dividers use to size their tick counters.

`ifndef AUX_SCAN_CNT_W
// Counter width needed to count 0..max-1 (at least one bit).
`define AUX_SCAN_CNT_W(max) (((max) > 1) ? $clog2(max) : 1)
`endif

`ifndef AUX_SCAN_LAST
// Terminal count of a 0..max-1 counter.
`define AUX_SCAN_LAST(max) ((max) - 1)
`endif

package aux_keypad_scanner_pkg;

  // Matrix is square: rows and columns share this count.
  localparam int unsigned KP_LINES   = 4;
  localparam int unsigned KEY_CODE_W = 4;

  // FSM encodings, 2-bit for compatibility with older controllers.
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  // Lowest-index low column wins when several are pressed on one row.
  function automatic logic [1:0] prio_col(input logic [KP_LINES-1:0] cols);
    logic [1:0] idx;
    if (!cols[0]) begin
      idx = 2'd0;
    end else if (!cols[1]) begin
      idx = 2'd1;
    end else if (!cols[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // One-hot active-low row drive for a row index.
  function automatic logic [KP_LINES-1:0] row_drive(input logic [1:0] idx);
    logic [KP_LINES-1:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/aux_sync2.sv
// aux_sync2: parameterised-width 2-flop synchronizer for asynchronous inputs
// (keypad columns, switches, resume lines). Reset loads ResetVal so that
// idle-high lines do not glitch active on reset release.

module aux_sync2 #(
  parameter int unsigned         Width    = 1,
  parameter logic [Width-1:0]    ResetVal = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  // Two back-to-back flops; only q is used by downstream logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aux_keypad_scanner.sv
// aux_keypad_scanner: scans a 4x4 active-low key matrix one row at a time,
// debounces presses and releases, and reports one key code per press.
// Optional auto-repeat of a held key is built when AUX_KEYPAD_REPEAT_EN is
// defined; the default build emits exactly one key_valid per press.
//
// state    | meaning
// SCAN     | rotating the driven row each tick, waiting for a low column
// DEBOUNCE | candidate key latched, counting consecutive low samples
// PRESSED  | key accepted, row parked, counting consecutive high samples

module aux_keypad_scanner
  import aux_keypad_scanner_pkg::*;
#(
  parameter int unsigned ScanCntMax    = 50000,
  parameter int unsigned DebounceScans = 4,
  parameter int unsigned RepeatScans   = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KP_LINES-1:0]   col_n,
  output logic [KP_LINES-1:0]   row_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held,
  output logic                  key_release
);

  localparam int unsigned      CNT_W    = `AUX_SCAN_CNT_W(ScanCntMax);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(`AUX_SCAN_LAST(ScanCntMax));
  localparam logic [3:0]       DEB_TGT  = 4'(DebounceScans);

  logic [KP_LINES-1:0] col_s;
  logic [CNT_W-1:0]    scan_cnt;
  logic                tick;
  logic [1:0]          state;
  logic [1:0]          row_idx;
  logic [1:0]          lat_col;
  logic [1:0]          det_col;
  logic [3:0]          deb_cnt;
  logic [3:0]          deb_next;
  logic                any_low;
  logic                lat_low;
  logic                rep_fire;

  aux_sync2 #(
    .Width    (KP_LINES),
    .ResetVal ({KP_LINES{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  assign tick     = (scan_cnt == CNT_LAST);
  assign any_low  = (col_s != {KP_LINES{1'b1}});
  assign det_col  = prio_col(col_s);
  assign lat_low  = ~col_s[lat_col];
  assign deb_next = deb_cnt + 4'd1;
  assign row_n    = row_drive(row_idx);

  // Scan tick: free-running 0..ScanCntMax-1 counter, tick on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Scan/debounce FSM; outputs are registered so pulses land one clk after the deciding tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SCAN;
      row_idx     <= 2'd0;
      lat_col     <= 2'd0;
      deb_cnt     <= 4'd0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (!any_low) begin
              row_idx <= row_idx + 2'd1;
            end else begin
              lat_col <= det_col;
              if (DEB_TGT == 4'd1) begin
                // Single-sample debounce: accept immediately, no DEBOUNCE dwell.
                state     <= ST_PRESSED;
                deb_cnt   <= 4'd0;
                key_code  <= {row_idx, det_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state   <= ST_DEBOUNCE;
                deb_cnt <= 4'd1;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (lat_low) begin
              if (deb_next == DEB_TGT) begin
                state     <= ST_PRESSED;
                deb_cnt   <= 4'd0;
                key_code  <= {row_idx, lat_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              // Bounce: drop the candidate silently and move on.
              state   <= ST_SCAN;
              deb_cnt <= 4'd0;
              row_idx <= row_idx + 2'd1;
            end
          end
          ST_PRESSED: begin
            if (!lat_low) begin
              if (deb_next == DEB_TGT) begin
                state       <= ST_SCAN;
                deb_cnt     <= 4'd0;
                row_idx     <= row_idx + 2'd1;
                key_held    <= 1'b0;
                key_release <= 1'b1;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= 4'd0;
              if (rep_fire) begin
                key_valid <= 1'b1;
              end
            end
          end
          default: begin
            state   <= ST_SCAN;
            deb_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef AUX_KEYPAD_REPEAT_EN
  localparam int unsigned      REP_W    = `AUX_SCAN_CNT_W(RepeatScans);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(`AUX_SCAN_LAST(RepeatScans));

  logic [REP_W-1:0] rep_cnt;

  assign rep_fire = tick && (state == ST_PRESSED) && lat_low && (rep_cnt == REP_LAST);

  // Auto-repeat interval: counts low samples while PRESSED, restarts on any high sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (tick) begin
      if ((state != ST_PRESSED) || !lat_low || rep_fire) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end
`else
  // Repeat interval has no effect when auto-repeat is compiled out.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^RepeatScans;
  assign rep_fire          = 1'b0;
`endif

endmodule

// File: tb/tb_aux_keypad_scanner.sv
// tb_aux_keypad_scanner: directed bench for the keypad scanner with a small
// behavioural key matrix. Main instance: ScanCntMax=4, DebounceScans=3,
// RepeatScans=5; second instance uses DebounceScans=1.

module tb_aux_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;
  logic [15:0] pressed1;

  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_held, key_release;
  logic [3:0] col1_n, row1_n, key_code1;
  logic       key_valid1, key_held1, key_release1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] row_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  function automatic logic [3:0] matrix(input logic [15:0] keys, input logic [3:0] rows);
    logic [3:0] cols;
    cols = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
      end
    end
    return cols;
  endfunction

  assign col_n  = matrix(pressed, row_n);
  assign col1_n = matrix(pressed1, row1_n);

  aux_keypad_scanner #(.ScanCntMax(4), .DebounceScans(3), .RepeatScans(5)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_release(key_release)
  );

  aux_keypad_scanner #(.ScanCntMax(4), .DebounceScans(1), .RepeatScans(5)) dut1 (
    .clk(clk), .rst(rst), .col_n(col1_n), .row_n(row1_n), .key_code(key_code1),
    .key_valid(key_valid1), .key_held(key_held1), .key_release(key_release1)
  );

  // Returns at the first negedge where the chosen instance drives the wanted row.
  task automatic wait_row(input bit which, input logic [3:0] want, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((which ? row1_n : row_n) === want) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: row %b never driven within 100 clk (last row %b)", name, want,
               which ? row1_n : row_n);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    pressed  = '0;
    pressed1 = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_row_n: got %b expected 1110", row_n); end
    tests_run++;
    if (key_code !== 4'h0) begin tests_failed++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
    tests_run++;
    if ({key_valid, key_held, key_release} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 000", {key_valid, key_held, key_release});
    end
    tests_run++;
    if (row1_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_row1_n: got %b expected 1110", row1_n); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    int valid_seen;
    valid_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (key_valid) valid_seen++;
      tests_run++;
      if (row_n !== row_tbl[(k/4)%4]) begin
        tests_failed++;
        $display("FAIL idle_row k=%0d: got %b expected %b", k, row_n, row_tbl[(k/4)%4]);
      end
    end
    tests_run++;
    if (valid_seen != 0) begin tests_failed++; $display("FAIL idle_no_valid: got %0d pulses expected 0", valid_seen); end
  endtask

  task automatic test_press();
    int lat;
    wait_row(1'b0, 4'b1110, "press_wait_row0");
    pressed[6] = 1'b1;
    wait_row(1'b0, 4'b1101, "press_wait_row1");
    lat = 0;
    while (!key_valid && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 12) begin tests_failed++; $display("FAIL press_latency: got %0d clk expected 12", lat); end
    tests_run++;
    if (key_code !== 4'h6) begin tests_failed++; $display("FAIL press_key_code: got %h expected 6", key_code); end
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL press_key_held: got %b expected 1", key_held); end
    @(negedge clk);
    tests_run++;
    if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL press_pulse_width: got %b expected 0", key_valid); end
    tests_run++;
    if (row_n !== 4'b1101) begin tests_failed++; $display("FAIL press_row_hold: got %b expected 1101", row_n); end
  endtask

  task automatic test_release();
    int lat;
    pressed[6] = 1'b0;
    lat = 0;
    while (!key_release && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 11) begin tests_failed++; $display("FAIL release_latency: got %0d clk expected 11", lat); end
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL release_key_held: got %b expected 0", key_held); end
    tests_run++;
    if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL release_no_valid: got %b expected 0", key_valid); end
    tests_run++;
    if (row_n !== 4'b1011) begin tests_failed++; $display("FAIL release_next_row: got %b expected 1011", row_n); end
    tests_run++;
    if (key_code !== 4'h6) begin tests_failed++; $display("FAIL release_code_hold: got %h expected 6", key_code); end
    @(negedge clk);
    tests_run++;
    if (key_release !== 1'b0) begin tests_failed++; $display("FAIL release_pulse_width: got %b expected 0", key_release); end
  endtask

  task automatic test_bounce();
    int valid_seen;
    valid_seen = 0;
    wait_row(1'b0, 4'b0111, "bounce_wait_row3");
    pressed[12] = 1'b1;
    repeat (4) begin @(negedge clk); if (key_valid) valid_seen++; end
    tests_run++;
    if (row_n !== 4'b0111) begin tests_failed++; $display("FAIL bounce_row_hold: got %b expected 0111", row_n); end
    pressed[12] = 1'b0;
    repeat (3) begin @(negedge clk); if (key_valid) valid_seen++; end
    tests_run++;
    if (row_n !== 4'b0111) begin tests_failed++; $display("FAIL bounce_row_dwell: got %b expected 0111", row_n); end
    @(negedge clk);
    if (key_valid) valid_seen++;
    tests_run++;
    if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL bounce_row_advance: got %b expected 1110", row_n); end
    repeat (8) begin @(negedge clk); if (key_valid) valid_seen++; end
    tests_run++;
    if (valid_seen != 0) begin tests_failed++; $display("FAIL bounce_no_valid: got %0d pulses expected 0", valid_seen); end
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL bounce_key_held: got %b expected 0", key_held); end
  endtask

  task automatic test_priority();
    int lat;
    int extra;
    int exp_extra;
    wait_row(1'b0, 4'b0111, "prio_wait_row3");
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    wait_row(1'b0, 4'b1110, "prio_wait_row0");
    lat = 0;
    while (!key_valid && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 12) begin tests_failed++; $display("FAIL prio_latency: got %0d clk expected 12", lat); end
    tests_run++;
    if (key_code !== 4'h1) begin tests_failed++; $display("FAIL prio_key_code: got %h expected 1", key_code); end
`ifdef AUX_KEYPAD_REPEAT_EN
    exp_extra = 2;
`else
    exp_extra = 0;
`endif
    extra = 0;
    repeat (40) begin @(negedge clk); if (key_valid) extra++; end
    tests_run++;
    if (extra != exp_extra) begin
      tests_failed++; $display("FAIL prio_extra_valid: got %0d pulses expected %0d", extra, exp_extra);
    end
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL prio_still_held: got %b expected 1", key_held); end
    pressed[1] = 1'b0;
    pressed[3] = 1'b0;
    lat = 0;
    while (!key_release && lat < 60) begin @(negedge clk); lat++; end
    tests_run++;
    if (!key_release) begin tests_failed++; $display("FAIL prio_release: got no pulse in %0d clk expected one", lat); end
  endtask

  task automatic test_reset_pressed();
    int lat;
    int stray;
    wait_row(1'b0, 4'b0111, "rstp_wait_row3");
    pressed[0] = 1'b1;
    lat = 0;
    while (!key_valid && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL rstp_held_before: got %b expected 1", key_held); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL rstp_row_n: got %b expected 1110", row_n); end
    tests_run++;
    if ({key_valid, key_held, key_release} !== 3'b000) begin
      tests_failed++; $display("FAIL rstp_flags: got %b expected 000", {key_valid, key_held, key_release});
    end
    tests_run++;
    if (key_code !== 4'h0) begin tests_failed++; $display("FAIL rstp_key_code: got %h expected 0", key_code); end
    pressed[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (30) begin @(negedge clk); if (key_release || key_valid) stray++; end
    tests_run++;
    if (stray != 0) begin tests_failed++; $display("FAIL rstp_no_pulse: got %0d pulses expected 0", stray); end
  endtask

  task automatic test_debounce_one();
    int lat;
    wait_row(1'b1, 4'b0111, "db1_wait_row3");
    pressed1[3] = 1'b1;
    wait_row(1'b1, 4'b1110, "db1_wait_row0");
    lat = 0;
    while (!key_valid1 && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL db1_latency: got %0d clk expected 4", lat); end
    tests_run++;
    if (key_code1 !== 4'h3) begin tests_failed++; $display("FAIL db1_key_code: got %h expected 3", key_code1); end
    tests_run++;
    if (key_held1 !== 1'b1) begin tests_failed++; $display("FAIL db1_key_held: got %b expected 1", key_held1); end
    @(negedge clk);
    pressed1[3] = 1'b0;
    lat = 0;
    while (!key_release1 && lat < 40) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 3) begin tests_failed++; $display("FAIL db1_release_latency: got %0d clk expected 3", lat); end
    tests_run++;
    if (row1_n !== 4'b1101) begin tests_failed++; $display("FAIL db1_next_row: got %b expected 1101", row1_n); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press();
    test_release();
    test_bounce();
    test_priority();
    test_reset_pressed();
    test_debounce_one();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
